ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Downstream of the PS/2 byte receiver. Consumes its 8-bit received_data / single-cycle received_data_en stream.
- Folds Set-2 prefix bytes (E0 extended, F0 break) into key events and diverts device status bytes to a separate pulse port.
- Buffers key events in a small show-ahead FIFO with a valid/ready interface for keyboard consumers (char mapper, CPU register bank).

Parameters:
- FIFO_AW, 3, log2 of event FIFO depth (default 8 entries).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush: decoder state and FIFO to reset state; outputs as after reset
- byte_data  in  8  received byte; sampled only when byte_valid=1
- byte_valid  in  1  one-cycle strobe per received byte
- evt_ready  in  1  consumer accepts the head event when evt_valid=1
- evt_valid  out  1  FIFO non-empty
- evt_code  out  8  head event scancode (final non-prefix byte)
- evt_ext  out  1  head event was E0-prefixed
- evt_brk  out  1  head event was F0-prefixed (key release)
- evt_count  out  FIFO_AW+1  current FIFO occupancy, 0..2^FIFO_AW
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full
- status_valid  out  1  one-cycle pulse when a status byte is received
- status_code  out  8  last status byte; holds until the next one

Behaviour:
- Reset/clear: state BASE; FIFO empty; evt_valid=0, evt_count=0, overflow=0, status_valid=0, status_code=8'h00.
- evt_code/evt_ext/evt_brk are don't-care while evt_valid=0.
- Status set: FA, AA, EE, FE, FC, 00, FF.
  - A status byte in BASE, EXT, BRK or EXT_BRK: status_valid=1 and status_code=byte in cycle N+1 (byte_valid in cycle N).
  - Decoder returns to BASE, discarding any pending prefix.
  - Nothing enters the FIFO.
- Decoder states: BASE, EXT, BRK, EXT_BRK, PAUSE (macro only). Non-status byte transitions:
  - BASE: E0→EXT; F0→BRK; otherwise emit {ext=0,brk=0,code}, stay in BASE.
  - EXT: F0→EXT_BRK; E0→EXT (repeat ignored); otherwise emit {1,0,code}→BASE.
  - BRK: F0→BRK; E0→EXT (prefix restart); otherwise emit {0,1,code}→BASE.
  - EXT_BRK: E0 or F0→EXT_BRK (ignored); otherwise emit {1,1,code}→BASE.
  - byte_valid=0: state holds.
- Emit timing: the FIFO write occurs at the clock edge ending cycle N. The event is visible at evt_* with evt_valid=1 in cycle N+1 when the FIFO was empty. No same-cycle bypass.
- Read: head is popped at a clock edge with evt_valid&evt_ready. evt_ready with evt_valid=0 is ignored.
- Full (count=2^FIFO_AW):
  - Emit with no pop in the same cycle: event dropped, overflow=1 in cycle N+1, FIFO contents unchanged.
  - Emit with a pop in the same cycle: write accepted, count stays full, no overflow.
- Empty: a simultaneous emit and evt_ready leaves count=1 (no pop of the absent entry).
- Pointers wrap modulo 2^FIFO_AW; count is a separate FIFO_AW+1-bit register.
- reset/clear mid-sequence (e.g. after E0): the prefix is lost; the next byte decodes from BASE.
- reset has priority over clear; clear has priority over byte_valid and evt_ready in the same cycle.

Optional Feature:
- Macro PS2_PAUSE_SEQ_EN.
- Defined:
  - E1 in BASE → PAUSE with a 3-bit skip counter=0.
  - In PAUSE, every byte_valid increments the counter (no status detection).
  - On the 7th byte: emit {0,0,8'hE1}→BASE. Pause key E1 14 77 E1 F0 14 F0 77 yields exactly one event.
  - E1 in EXT/BRK/EXT_BRK is decoded as an ordinary code.
- Undefined:
  - No PAUSE state; E1 is an ordinary code everywhere.
  - The pause sequence yields events (0,0,E1),(0,0,14),(0,0,77),(0,0,E1),(0,1,14),(0,1,77).

Test Plan:
- Bytes 1C, F0 1C with evt_ready=1 → events {0,0,1C} then {0,1,1C}; evt_valid first high the cycle after the 1C strobe.
- Bytes E0 75, E0 F0 75 → {1,0,75}, {1,1,75}; no events for prefix bytes.
- Byte E0 then AA → status_valid pulse with status_code=AA, no event; following 75 → {0,0,75}.
- evt_ready=0, 9 make codes 01..09 (FIFO_AW=3) → evt_count=8, one overflow pulse on 09; draining yields 01..08. Repeat with evt_ready=1 pulsed during the 9th emit → no overflow, 02..09 remain.
- Byte F0, clear for 1 cycle, then 1C → {0,0,1C}, evt_count was 0 after clear.
- Pause sequence E1 14 77 E1 F0 14 F0 77 → with PS2_PAUSE_SEQ_EN: single {0,0,E1}; without: six events as listed above.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Folds PS/2 Set-2 prefix bytes (E0 extended, F0 break) into key events,
// diverts device status bytes (FA AA EE FE FC 00 FF) to a pulse port, and
// buffers key events in a show-ahead FIFO with a valid/ready interface.
//
// Optional build macro PS2_PAUSE_SEQ_EN: when defined, the 8-byte Pause
// sequence (E1 + 7 bytes) collapses into a single {0,0,E1} event. When it
// is undefined, E1 is an ordinary code in every state.
//
// Handshake: evt_valid is high whenever the FIFO holds an event; the head
// event (evt_code/evt_ext/evt_brk) is consumed at the clock edge where
// evt_valid and evt_ready are both high. evt_ready while evt_valid is low
// has no effect. The event fields are meaningless while evt_valid is low.

module ps2_scancode_decoder #(
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [7:0]         byte_data,
  input  logic               byte_valid,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic [7:0]         evt_code,
  output logic               evt_ext,
  output logic               evt_brk,
  output logic [FIFO_AW:0]   evt_count,
  output logic               overflow,
  output logic               status_valid,
  output logic [7:0]         status_code
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    ST_BASE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic       is_status;
  logic       status_hit;
  logic       emit;
  logic       emit_ext;
  logic       emit_brk;
  logic [7:0] emit_code;

`ifdef PS2_PAUSE_SEQ_EN
  // Counts the bytes following E1; the 7th one closes the Pause sequence.
  logic [2:0] pause_cnt;
  logic [2:0] pause_cnt_nxt;
`endif

  // Device status bytes are never part of a key sequence.
  always_comb begin
    is_status = 1'b0;
    case (byte_data)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_status = 1'b1;
      default:                                         is_status = 1'b0;
    endcase
  end

  // Next-state and event-emit decode for one received byte.
  always_comb begin
    state_nxt  = state;
    status_hit = 1'b0;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_brk   = 1'b0;
    emit_code  = byte_data;
`ifdef PS2_PAUSE_SEQ_EN
    pause_cnt_nxt = pause_cnt;
`endif
    if (byte_valid) begin
`ifdef PS2_PAUSE_SEQ_EN
      if (state == ST_PAUSE) begin
        // Inside Pause every byte is payload, even ones that look like status.
        if (pause_cnt == 3'd6) begin
          emit          = 1'b1;
          emit_code     = 8'hE1;
          state_nxt     = ST_BASE;
          pause_cnt_nxt = 3'd0;
        end else begin
          pause_cnt_nxt = pause_cnt + 3'd1;
        end
      end else
`endif
      if (is_status) begin
        // A status byte cancels any pending prefix.
        status_hit = 1'b1;
        state_nxt  = ST_BASE;
      end else begin
        case (state)
          ST_BASE: begin
            if (byte_data == 8'hE0) begin
              state_nxt = ST_EXT;
            end else if (byte_data == 8'hF0) begin
              state_nxt = ST_BRK;
`ifdef PS2_PAUSE_SEQ_EN
            end else if (byte_data == 8'hE1) begin
              state_nxt     = ST_PAUSE;
              pause_cnt_nxt = 3'd0;
`endif
            end else begin
              emit = 1'b1;
            end
          end
          ST_EXT: begin
            if (byte_data == 8'hF0) begin
              state_nxt = ST_EXT_BRK;
            end else if (byte_data == 8'hE0) begin
              state_nxt = ST_EXT;
            end else begin
              emit      = 1'b1;
              emit_ext  = 1'b1;
              state_nxt = ST_BASE;
            end
          end
          ST_BRK: begin
            if (byte_data == 8'hF0) begin
              state_nxt = ST_BRK;
            end else if (byte_data == 8'hE0) begin
              // E0 after F0 restarts the prefix as an extended sequence.
              state_nxt = ST_EXT;
            end else begin
              emit      = 1'b1;
              emit_brk  = 1'b1;
              state_nxt = ST_BASE;
            end
          end
          ST_EXT_BRK: begin
            if ((byte_data == 8'hE0) || (byte_data == 8'hF0)) begin
              state_nxt = ST_EXT_BRK;
            end else begin
              emit      = 1'b1;
              emit_ext  = 1'b1;
              emit_brk  = 1'b1;
              state_nxt = ST_BASE;
            end
          end
          default: state_nxt = ST_BASE;
        endcase
      end
    end
  end

  // Decoder FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state        <= ST_BASE;
      status_valid <= 1'b0;
      status_code  <= 8'h00;
`ifdef PS2_PAUSE_SEQ_EN
      pause_cnt    <= 3'd0;
`endif
    end else begin
      state        <= state_nxt;
      status_valid <= status_hit;
      if (status_hit) begin
        status_code <= byte_data;
      end
`ifdef PS2_PAUSE_SEQ_EN
      pause_cnt    <= pause_cnt_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO: entries are {ext, brk, code}; occupancy kept in its own
  // register so full (count = DEPTH) and empty are unambiguous.
  // ---------------------------------------------------------------------
  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic               flush;

  assign flush     = reset || clear;
  assign evt_valid = (evt_count != '0);
  assign full      = evt_count[FIFO_AW];
  assign pop       = evt_valid && evt_ready && !flush;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign wr_en     = emit && (!full || pop) && !flush;

  assign evt_ext  = mem[rd_ptr][9];
  assign evt_brk  = mem[rd_ptr][8];
  assign evt_code = mem[rd_ptr][7:0];

  // Event storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {emit_ext, emit_brk, emit_code};
    end
  end

  // Pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      overflow <= emit && full && !pop;
      case ({wr_en, pop})
        2'b10:   evt_count <= evt_count + 1'b1;
        2'b01:   evt_count <= evt_count - 1'b1;
        default: evt_count <= evt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed test-plan
// sequences with literal expectations, then randomized traffic, all
// compared every cycle against a prefix-flag / queue model of the decoder.
// Honors PS2_PAUSE_SEQ_EN the same way the design does.

module tb_ps2_scancode_decoder;

  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 1 << FIFO_AW;
`ifdef PS2_PAUSE_SEQ_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             evt_ready;
  logic             evt_valid;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_brk;
  logic [FIFO_AW:0] evt_count;
  logic             overflow;
  logic             status_valid;
  logic [7:0]       status_code;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.FIFO_AW(FIFO_AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .evt_ready    (evt_ready),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_brk      (evt_brk),
    .evt_count    (evt_count),
    .overflow     (overflow),
    .status_valid (status_valid),
    .status_code  (status_code)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_status(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE) ||
           (b == 8'hFC) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // ---------------- behavioural model ----------------
  // Pending prefixes are two independent flags; events live in a queue.
  logic [9:0] m_q[$];
  bit         m_ext, m_brk, m_pause, m_ovf, m_stv, m_started;
  int         m_skip;
  logic [7:0] m_stc;

  // Model advances on each clock edge using the inputs that edge samples.
  always @(posedge clk) begin
    bit         emit;
    bit         do_pop;
    logic [9:0] ev;
    logic [7:0] b;
    m_ovf = 1'b0;
    m_stv = 1'b0;
    if (reset || clear) begin
      m_q.delete();
      m_ext   = 1'b0;
      m_brk   = 1'b0;
      m_pause = 1'b0;
      m_skip  = 0;
      m_stc   = 8'h00;
    end else begin
      do_pop = (m_q.size() != 0) && evt_ready;
      emit   = 1'b0;
      ev     = '0;
      b      = byte_data;
      if (byte_valid) begin
        if (m_pause) begin
          m_skip++;
          if (m_skip == 7) begin
            emit    = 1'b1;
            ev      = {2'b00, 8'hE1};
            m_pause = 1'b0;
          end
        end else if (is_status(b)) begin
          m_stv = 1'b1;
          m_stc = b;
          m_ext = 1'b0;
          m_brk = 1'b0;
        end else if (b == 8'hE0) begin
          if (!(m_ext && m_brk)) begin
            m_ext = 1'b1;
            m_brk = 1'b0;
          end
        end else if (b == 8'hF0) begin
          m_brk = 1'b1;
        end else if (PAUSE_EN && (b == 8'hE1) && !m_ext && !m_brk) begin
          m_pause = 1'b1;
          m_skip  = 0;
        end else begin
          emit  = 1'b1;
          ev    = {m_ext, m_brk, b};
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (emit) begin
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(ev);
      end
    end
    m_started = 1'b1;
  end

  // ---------------- compare + monitor (opposite edge) ----------------
  logic [9:0] got_q[$];
  int         ovf_n = 0;
  int         st_n  = 0;

  // Every cycle: DUT outputs against the model, and log consumed events.
  always @(negedge clk) begin
    if (m_started && !reset) begin
      check("evt_valid", evt_valid, m_q.size() != 0);
      check("evt_count", evt_count, m_q.size());
      if (m_q.size() != 0) check("evt_head", {evt_ext, evt_brk, evt_code}, m_q[0]);
      check("overflow", overflow, m_ovf);
      check("status_valid", status_valid, m_stv);
      check("status_code", status_code, m_stc);
      if (evt_valid && evt_ready && !clear) got_q.push_back({evt_ext, evt_brk, evt_code});
      if (overflow) ovf_n++;
      if (status_valid) st_n++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] b, input logic r, input logic c);
    byte_valid = v;
    byte_data  = b;
    evt_ready  = r;
    clear      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic r);
    drive(1'b1, b, r, 1'b0);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, r, 1'b0);
  endtask

  // Pops until empty within a fixed cycle budget.
  task automatic drain(input string name);
    for (int i = 0; i < 4 * DEPTH && evt_count != 0; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    check(name, evt_count, 0);
    idle(1, 1'b0);
  endtask

  logic [9:0] exp_q[$];

  task automatic check_events(input string name);
    check({name, "_n"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(name, got_q[i], exp_q[i]);
    got_q.delete();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] st_tab [7];
  int         ovf0, st0;

  initial begin
    st_tab = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};
    reset = 1'b1; clear = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_count", evt_count, 0);
    check("reset_valid", evt_valid, 0);
    check("reset_status_code", status_code, 8'h00);
    idle(2, 1'b0);
    got_q.delete();

    // make/break of the same key
    send(8'h1C, 1'b1);
    check("first_evt_valid", evt_valid, 1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1);
    idle(3, 1'b1);
    exp_q = '{10'h01C, 10'h11C};
    check_events("make_break");

    // extended make/break
    send(8'hE0, 1'b1); send(8'h75, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1);
    idle(3, 1'b1);
    exp_q = '{10'h275, 10'h375};
    check_events("ext_make_break");

    // status byte cancels a pending E0
    st0 = st_n;
    send(8'hE0, 1'b1); send(8'hAA, 1'b1);
    idle(1, 1'b1);
    check("status_pulses", st_n - st0, 1);
    check("status_aa", status_code, 8'hAA);
    send(8'h75, 1'b1);
    idle(3, 1'b1);
    exp_q = '{10'h075};
    check_events("after_status");

    // fill past full with no consumer
    ovf0 = ovf_n;
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0);
    idle(1, 1'b0);
    check("full_count", evt_count, DEPTH);
    check("full_ovf_pulses", ovf_n - ovf0, 1);
    drain("drain_full");
    exp_q = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008};
    check_events("full_drain");

    // emit while full with a simultaneous pop
    ovf0 = ovf_n;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    send(8'h09, 1'b1);
    idle(1, 1'b0);
    check("full_pop_count", evt_count, DEPTH);
    check("full_pop_no_ovf", ovf_n - ovf0, 0);
    got_q.delete();
    drain("drain_full_pop");
    exp_q = '{10'h002, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007, 10'h008, 10'h009};
    check_events("full_pop_drain");

    // clear drops a pending F0
    send(8'hF0, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    check("clear_count", evt_count, 0);
    send(8'h1C, 1'b1);
    idle(3, 1'b1);
    exp_q = '{10'h01C};
    check_events("after_clear");

    // Pause key sequence
    send(8'hE1, 1'b1); send(8'h14, 1'b1); send(8'h77, 1'b1); send(8'hE1, 1'b1);
    send(8'hF0, 1'b1); send(8'h14, 1'b1); send(8'hF0, 1'b1); send(8'h77, 1'b1);
    idle(3, 1'b1);
    if (PAUSE_EN) exp_q = '{10'h0E1};
    else exp_q = '{10'h0E1, 10'h014, 10'h077, 10'h0E1, 10'h114, 10'h177};
    check_events("pause_seq");

    // randomized traffic, alternating consumer-heavy and consumer-light phases
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 400; i++) begin
        logic [7:0] b;
        logic       v, r, c;
        case ($urandom_range(0, 9))
          0:       b = 8'hE0;
          1, 2:    b = 8'hF0;
          3:       b = 8'hE1;
          4:       b = st_tab[$urandom_range(0, 6)];
          default: b = 8'($urandom_range(0, 255));
        endcase
        v = ($urandom_range(0, 2) != 0);
        r = (ph[0]) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        c = ($urandom_range(0, 199) == 0);
        drive(v, b, r, c);
      end
    end
    idle(2, 1'b0);
    reset = 1'b1;
    idle(2, 1'b0);
    reset = 1'b0;
    check("final_reset_count", evt_count, 0);
    idle(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
